// File: rtl/enc_8b10b_rd.sv
// Registered 8b/10b encoder with running-disparity tracking and a single valid/ready output stage.
// Optional macro ENC_KCHAR_EN enables the K-character table and the k_err flag.
module enc_8b10b_rd #(
    parameter logic RD_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       k_in,
    input  logic       valid_in,
    output logic       ready_in,
    output logic [9:0] code_out,
    output logic       valid_out,
    input  logic       ready_out,
    output logic       rd_out,
    output logic       k_err
);

    // RD- forms of the 5b/6b table (abcdei); RD+ forms are derived by complement
    function automatic logic [5:0] d6_rdm(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // RD- forms of the 3b/4b table (fghj); y=7 picks primary or alternate form
    function automatic logic [3:0] d4_rdm(input logic [2:0] y, input logic a7);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = a7 ? 4'b0111 : 4'b1110;
        endcase
        return c;
    endfunction

    logic [9:0] code_q;
    logic       valid_q;
    logic       rd_q;
    logic       accept;

    logic [4:0] x;
    logic [2:0] y;
    logic       k_legal;
    logic       k28;
    logic       kerr_d;

    assign x = data_in[4:0];
    assign y = data_in[7:5];

`ifdef ENC_KCHAR_EN
    assign k28     = k_in & (x == 5'd28);
    assign k_legal = k28 | (k_in & (y == 3'd7) &
                     ((x == 5'd23) | (x == 5'd27) | (x == 5'd29) | (x == 5'd30)));
    assign kerr_d  = k_in & ~k_legal;
`else
    logic unused_k;
    assign unused_k = k_in;
    assign k28      = 1'b0;
    assign k_legal  = 1'b0;
    assign kerr_d   = 1'b0;
`endif

    logic [5:0] c6, code6;
    logic [3:0] c4, code4;
    logic       unbal6, unbal4, rd1, a7, alt4, rd_d;
    logic [9:0] code_d;

    always_comb begin
        c6     = k28 ? 6'b001111 : d6_rdm(x);
        unbal6 = ($countones(c6) != 3);
        // D.7 is neutral but still has distinct RD-/RD+ forms
        code6  = (rd_q & (unbal6 | (x == 5'd7))) ? ~c6 : c6;
        rd1    = rd_q ^ unbal6;
        // Alternate 7 avoids a run of five across the 6b/4b boundary
        a7     = k_legal
               | (~rd1 & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20)))
               | ( rd1 & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14)));
        c4     = d4_rdm(y, a7);
        unbal4 = ($countones(c4) != 2);
        // K28 neutral 4b forms alternate with RD1 so the comma pairs stay balanced
        alt4   = rd1 ? (unbal4 | (y == 3'd3))
                     : (k28 & ~unbal4 & (y != 3'd3));
        code4  = alt4 ? ~c4 : c4;
        rd_d   = rd1 ^ unbal4;
        code_d = {code6, code4};
    end

    assign ready_in = ~valid_q | ready_out;
    assign accept   = valid_in & ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            rd_q    <= RD_INIT;
        end else if (accept) begin
            valid_q <= 1'b1;
            code_q  <= code_d;
            rd_q    <= rd_d;
        end else if (ready_out) begin
            valid_q <= 1'b0;
        end
    end

`ifdef ENC_KCHAR_EN
    logic kerr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            kerr_q <= 1'b0;
        else if (accept)
            kerr_q <= kerr_d;
    end
    assign k_err = kerr_q;
`else
    logic unused_kerr;
    assign unused_kerr = kerr_d;
    assign k_err       = 1'b0;
`endif

    assign code_out  = code_q;
    assign valid_out = valid_q;
    assign rd_out    = rd_q;

endmodule
